// File: rtl/pred_table_ctrl_pkg.sv
// Shared types and helpers for the branch prediction table update controller.
// The update record is sized for the widest supported configuration; the top
// zero-extends narrower indices and counters into it.
package pred_table_ctrl_pkg;

  // Upper bounds on INDEX_WIDTH / JUMP_STATUS_COUNTER_WIDTH for the shared record.
  localparam int unsigned PRED_IDX_MAX_W = 16;
  localparam int unsigned PRED_CNT_MAX_W = 8;

  typedef enum logic [0:0] {
    StClear,
    StRun
  } pred_state_e;

  typedef struct packed {
    logic [PRED_IDX_MAX_W-1:0] index;
    logic [PRED_CNT_MAX_W-1:0] count;
    logic                      taken;
  } pred_upd_t;

  // Saturating counter step towards taken / not-taken, clamped at 0 and cnt_max.
  function automatic logic [PRED_CNT_MAX_W-1:0] pred_next_count(
    input logic [PRED_CNT_MAX_W-1:0] count,
    input logic                      taken,
    input logic [PRED_CNT_MAX_W-1:0] cnt_max
  );
    if (taken) begin
      return (count == cnt_max) ? cnt_max : count + PRED_CNT_MAX_W'(1);
    end
    return (count == '0) ? '0 : count - PRED_CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pred_upd_fifo.sv
// Per-requester update FIFO. Pointers carry one extra wrap bit so that full and
// empty are distinguishable with DEPTH a power of two.
module pred_upd_fifo
  import pred_table_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  pred_upd_t i_data,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output pred_upd_t o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  pred_upd_t   r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage needs no reset: entries are only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/pred_table_ctrl.sv
// Prediction table controller: clears the table after reset, then drains two
// requester update FIFOs into the two table write ports.
// Optional feature: define PRED_UPD_MERGE_EN to merge same-index updates from
// both FIFO heads into a single port-1 write.
module pred_table_ctrl
  import pred_table_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH               = 8,
  parameter int unsigned JUMP_STATUS_COUNTER_WIDTH = 2,
  parameter int unsigned QUEUE_DEPTH               = 4,
  parameter int unsigned INIT_COUNT                = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 upd0_valid,
  output logic                                 upd0_ready,
  input  logic [INDEX_WIDTH-1:0]               upd0_index,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] upd0_count,
  input  logic                                 upd0_taken,
  input  logic                                 upd1_valid,
  output logic                                 upd1_ready,
  input  logic [INDEX_WIDTH-1:0]               upd1_index,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] upd1_count,
  input  logic                                 upd1_taken,
  output logic                                 WR_en1,
  output logic [INDEX_WIDTH-1:0]               WR_index1,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_count1,
  output logic                                 WR_en2,
  output logic [INDEX_WIDTH-1:0]               WR_index2,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_count2,
  output logic                                 init_done
);

  localparam int unsigned CW = JUMP_STATUS_COUNTER_WIDTH;
  localparam logic [PRED_CNT_MAX_W-1:0] CNT_MAX = PRED_CNT_MAX_W'((1 << CW) - 1);
  localparam logic [CW-1:0] INIT_VAL = CW'(INIT_COUNT);

  pred_state_e              r_state;
  pred_state_e              w_state_next;
  logic [INDEX_WIDTH-1:0]   r_ptr;
  logic                     w_clear_last;

  pred_upd_t                w_rec0, w_rec1, w_head0, w_head1;
  logic                     w_full0, w_full1, w_empty0, w_empty1;
  logic                     w_pop0, w_pop1, w_collide;

  logic                     w_en1_d, w_en2_d;
  logic [INDEX_WIDTH-1:0]   w_idx1_d, w_idx2_d;
  logic [CW-1:0]            w_cnt1_d, w_cnt2_d;

  // ptr is always even; the last clear cycle writes the top two indices.
  assign w_clear_last = (r_ptr == ~INDEX_WIDTH'(1));
  assign w_collide    = !w_empty0 && !w_empty1 && (w_head0.index == w_head1.index);

  // Widen requester fields into the shared record.
  always_comb begin
    w_rec0                        = '0;
    w_rec0.index[INDEX_WIDTH-1:0] = upd0_index;
    w_rec0.count[CW-1:0]          = upd0_count;
    w_rec0.taken                  = upd0_taken;
    w_rec1                        = '0;
    w_rec1.index[INDEX_WIDTH-1:0] = upd1_index;
    w_rec1.count[CW-1:0]          = upd1_count;
    w_rec1.taken                  = upd1_taken;
  end

  pred_upd_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (upd0_valid && upd0_ready),
    .i_data  (w_rec0),
    .i_pop   (w_pop0),
    .o_full  (w_full0),
    .o_empty (w_empty0),
    .o_head  (w_head0)
  );

  pred_upd_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (upd1_valid && upd1_ready),
    .i_data  (w_rec1),
    .i_pop   (w_pop1),
    .o_full  (w_full1),
    .o_empty (w_empty1),
    .o_head  (w_head1)
  );

  // FSM state and clear pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StClear;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StClear) r_ptr <= r_ptr + INDEX_WIDTH'(2);
    end
  end

  // Next state: leave CLEAR once the final index pair has been issued.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StClear: if (w_clear_last) w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StClear;
    endcase
  end

  // Outputs: ready/init_done, FIFO pops and next values of the write registers.
  always_comb begin
    upd0_ready = 1'b0;
    upd1_ready = 1'b0;
    init_done  = 1'b0;
    w_pop0     = 1'b0;
    w_pop1     = 1'b0;
    w_en1_d    = 1'b0;
    w_en2_d    = 1'b0;
    w_idx1_d   = WR_index1;
    w_cnt1_d   = WR_count1;
    w_idx2_d   = WR_index2;
    w_cnt2_d   = WR_count2;
    unique case (r_state)
      StClear: begin
        w_en1_d  = 1'b1;
        w_idx1_d = r_ptr;
        w_cnt1_d = INIT_VAL;
        w_en2_d  = 1'b1;
        w_idx2_d = r_ptr + INDEX_WIDTH'(1);
        w_cnt2_d = INIT_VAL;
      end
      StRun: begin
        init_done  = 1'b1;
        upd0_ready = !w_full0;
        upd1_ready = !w_full1;
        if (!w_empty0) begin
          w_en1_d  = 1'b1;
          w_idx1_d = INDEX_WIDTH'(w_head0.index);
          w_cnt1_d = CW'(pred_next_count(w_head0.count, w_head0.taken, CNT_MAX));
          w_pop0   = 1'b1;
        end
        if (!w_empty1) begin
          if (!w_collide) begin
            w_en2_d  = 1'b1;
            w_idx2_d = INDEX_WIDTH'(w_head1.index);
            w_cnt2_d = CW'(pred_next_count(w_head1.count, w_head1.taken, CNT_MAX));
            w_pop1   = 1'b1;
          end else begin
`ifdef PRED_UPD_MERGE_EN
            // Fold head1's outcome on top of head0's into one port-1 write.
            w_cnt1_d = CW'(pred_next_count(
                pred_next_count(w_head0.count, w_head0.taken, CNT_MAX),
                w_head1.taken, CNT_MAX));
            w_pop1   = 1'b1;
`else
            // head1 waits; head0 owns the index this cycle.
            w_pop1   = 1'b0;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  // Registered table write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WR_en1    <= 1'b0;
      WR_index1 <= '0;
      WR_count1 <= '0;
      WR_en2    <= 1'b0;
      WR_index2 <= '0;
      WR_count2 <= '0;
    end else begin
      WR_en1    <= w_en1_d;
      WR_index1 <= w_idx1_d;
      WR_count1 <= w_cnt1_d;
      WR_en2    <= w_en2_d;
      WR_index2 <= w_idx2_d;
      WR_count2 <= w_cnt2_d;
    end
  end

endmodule

// File: tb/tb_pred_table_ctrl.sv
// Self-checking bench for pred_table_ctrl: queue-based reference model,
// directed scenarios and randomized traffic. Honours PRED_UPD_MERGE_EN.
module tb_pred_table_ctrl;

  localparam int IW     = 8;
  localparam int CW     = 2;
  localparam int QD     = 4;
  localparam int INIT   = 1;
  localparam int TDEPTH = 1 << IW;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          upd0_valid = 1'b0, upd1_valid = 1'b0;
  logic          upd0_ready, upd1_ready;
  logic [IW-1:0] upd0_index = '0, upd1_index = '0;
  logic [CW-1:0] upd0_count = '0, upd1_count = '0;
  logic          upd0_taken = 1'b0, upd1_taken = 1'b0;
  logic          WR_en1, WR_en2, init_done;
  logic [IW-1:0] WR_index1, WR_index2;
  logic [CW-1:0] WR_count1, WR_count2;

  pred_table_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd0_valid (upd0_valid),
    .upd0_ready (upd0_ready),
    .upd0_index (upd0_index),
    .upd0_count (upd0_count),
    .upd0_taken (upd0_taken),
    .upd1_valid (upd1_valid),
    .upd1_ready (upd1_ready),
    .upd1_index (upd1_index),
    .upd1_count (upd1_count),
    .upd1_taken (upd1_taken),
    .WR_en1     (WR_en1),
    .WR_index1  (WR_index1),
    .WR_count1  (WR_count1),
    .WR_en2     (WR_en2),
    .WR_index2  (WR_index2),
    .WR_count2  (WR_count2),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: table-update semantics expressed with queues and integers.
  typedef struct {
    int idx;
    int cnt;
    bit taken;
  } upd_s;

  upd_s q0[$];
  upd_s q1[$];
  int   m_clear_cnt;
  bit   m_run;
  bit   m_en1, m_en2;
  int   m_idx1, m_cnt1, m_idx2, m_cnt2;

  int   cyc;
  int   first_done_cyc;
  bit   track_clear;
  bit   seen [TDEPTH];

  function automatic int sat_next(input int c, input bit t);
    if (t) return (c < CMAX) ? c + 1 : CMAX;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_clear_cnt = 0;
    m_run = 0;
    m_en1 = 0; m_en2 = 0;
    m_idx1 = 0; m_cnt1 = 0; m_idx2 = 0; m_cnt2 = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit   acc0, acc1, same;
    upd_s h0, h1, r;
    acc0 = upd0_valid && m_run && (q0.size() < QD);
    acc1 = upd1_valid && m_run && (q1.size() < QD);
    m_en1 = 0;
    m_en2 = 0;
    if (!m_run) begin
      m_en1 = 1; m_idx1 = 2 * m_clear_cnt;     m_cnt1 = INIT;
      m_en2 = 1; m_idx2 = 2 * m_clear_cnt + 1; m_cnt2 = INIT;
      m_clear_cnt++;
      if (m_clear_cnt == TDEPTH / 2) m_run = 1;
    end else begin
      same = (q0.size() > 0) && (q1.size() > 0) && (q0[0].idx == q1[0].idx);
      if (q0.size() > 0) begin
        h0 = q0.pop_front();
        m_en1 = 1; m_idx1 = h0.idx; m_cnt1 = sat_next(h0.cnt, h0.taken);
      end
      if (q1.size() > 0) begin
        if (!same) begin
          h1 = q1.pop_front();
          m_en2 = 1; m_idx2 = h1.idx; m_cnt2 = sat_next(h1.cnt, h1.taken);
        end else begin
`ifdef PRED_UPD_MERGE_EN
          h1 = q1.pop_front();
          m_cnt1 = sat_next(m_cnt1, h1.taken);
`endif
        end
      end
    end
    if (acc0) begin
      r.idx = upd0_index; r.cnt = upd0_count; r.taken = upd0_taken;
      q0.push_back(r);
    end
    if (acc1) begin
      r.idx = upd1_index; r.cnt = upd1_count; r.taken = upd1_taken;
      q1.push_back(r);
    end
  endtask

  task automatic check_outputs();
    check_val("upd0_ready", upd0_ready, m_run && (q0.size() < QD));
    check_val("upd1_ready", upd1_ready, m_run && (q1.size() < QD));
    check_val("init_done", init_done, m_run);
    check_val("WR_en1", WR_en1, m_en1);
    check_val("WR_index1", WR_index1, m_idx1);
    check_val("WR_count1", WR_count1, m_cnt1);
    check_val("WR_en2", WR_en2, m_en2);
    check_val("WR_index2", WR_index2, m_idx2);
    check_val("WR_count2", WR_count2, m_cnt2);
    if (init_done === 1'b1 && first_done_cyc < 0) first_done_cyc = cyc;
    if (track_clear) begin
      if (WR_en1 === 1'b1 && WR_count1 == CW'(INIT)) seen[WR_index1] = 1;
      if (WR_en2 === 1'b1 && WR_count2 == CW'(INIT)) seen[WR_index2] = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    upd0_valid = 0;
    upd1_valid = 0;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    cyc = 1;
    first_done_cyc = -1;
  endtask

  task automatic run_clear_check();
    int n;
    foreach (seen[i]) seen[i] = 0;
    track_clear = 1;
    repeat (130) tick();
    track_clear = 0;
    check_val("init_done_cycle", first_done_cyc, 129);
    n = 0;
    foreach (seen[i]) n += seen[i];
    check_val("clear_coverage", n, TDEPTH);
  endtask

  task automatic drive(input bit v0, input int i0, input int c0, input bit t0,
                       input bit v1, input int i1, input int c1, input bit t1);
    upd0_valid = v0; upd0_index = IW'(i0); upd0_count = CW'(c0); upd0_taken = t0;
    upd1_valid = v1; upd1_index = IW'(i1); upd1_count = CW'(c1); upd1_taken = t1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic random_traffic(input int n, input int idx_span);
    repeat (n) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, idx_span), $urandom_range(0, CMAX),
            $urandom_range(0, 1), $urandom_range(0, 99) < 60, $urandom_range(0, idx_span),
            $urandom_range(0, CMAX), $urandom_range(0, 1));
      tick();
    end
  endtask

  initial begin
    int  acc;
    bit  got;
    model_reset();
    cyc = 0;
    first_done_cyc = -1;
    track_clear = 0;

    // Power-up clear.
    @(posedge clk);
    apply_reset();
    run_clear_check();

    // Single updates on each requester, including saturation at both ends.
    drive(1, 5, 3, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 9, 0, 0); tick();
    idle(4);

    // Same-index collision.
    drive(1, 7, 1, 1, 1, 7, 2, 1); tick();
    idle(5);

    // Requester 1 stalled behind repeated collisions until its FIFO fills.
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 3, k % 4, 1, 1, 3, 2, k[0]);
      @(negedge clk);
      acc += int'(upd1_ready);
      @(posedge clk); #1;
      cyc++;
      // Re-run this cycle through the model-checked path.
      model_step();
    end
`ifdef PRED_UPD_MERGE_EN
    check_val("stall_accepts", acc, 5);
`else
    check_val("stall_accepts", acc, 4);
`endif
    // Held fifth request must be taken once requester 0 stops colliding.
    upd0_valid = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (upd1_ready === 1'b1) got = 1;
      check_outputs();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
    end
    check_val("held_push_accepted", got, 1);
    idle(8);

    // Randomized traffic: dense collisions, then wide index range.
    random_traffic(1500, 3);
    random_traffic(1000, TDEPTH - 1);

    // Reset mid-RUN with queued updates.
    drive(1, 1, 1, 1, 1, 2, 2, 0); tick(); tick();
    apply_reset();
    run_clear_check();
    random_traffic(200, 7);
    idle(6);

    // Reset mid-CLEAR at ptr = 40.
    apply_reset();
    repeat (20) tick();
    apply_reset();
    run_clear_check();
    random_traffic(300, 2);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pred_table_ctrl.md
PRED_TABLE_CTRL -- requirements
Module: pred_table_ctrl

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 8: prediction-table index width; table depth is 2^INDEX_WIDTH.
REQ-002 SHALL have parameter JUMP_STATUS_COUNTER_WIDTH, default 2: saturating counter width.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4: per-requester update FIFO depth, a power of two, at least 2.
REQ-004 SHALL have parameter INIT_COUNT, default 1: counter value written during clear (weakly not-taken).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Ports:
- clk  in  1: clock.
- rst_n  in  1: asynchronous active-low reset.
- upd0_valid  in  1: requester 0 (EX-stage branch resolve) update request.
- upd0_ready  out  1: requester 0 FIFO can accept an update.
- upd0_index  in  INDEX_WIDTH: table index for requester 0.
- upd0_count  in  JUMP_STATUS_COUNTER_WIDTH: counter value read at prediction time.
- upd0_taken  in  1: resolved branch outcome.
- upd1_valid, upd1_ready, upd1_index, upd1_count, upd1_taken: requester 1 (second resolve slot), same widths and meanings.
- WR_en1, WR_index1, WR_count1  out  1/INDEX_WIDTH/JUMP_STATUS_COUNTER_WIDTH: table write port 1.
- WR_en2, WR_index2, WR_count2  out  1/INDEX_WIDTH/JUMP_STATUS_COUNTER_WIDTH: table write port 2.
- init_done  out  1: table clear complete; high only in RUN.

Function
REQ-007 SHALL implement a two-state FSM with states CLEAR and RUN; reset enters CLEAR with clear pointer 0.
REQ-008 In CLEAR, each cycle SHALL write INIT_COUNT to index ptr on port 1 and to index ptr+1 on port 2, then advance ptr by 2.
REQ-009 CLEAR SHALL move to RUN after the cycle that writes index 2^INDEX_WIDTH-1; clear lasts 2^(INDEX_WIDTH-1) cycles (128 at default).
REQ-010 In CLEAR, upd0_ready and upd1_ready SHALL be 0 and no FIFO push SHALL occur.
REQ-011 A push SHALL occur on a cycle when updN_valid and updN_ready are both high; ready SHALL be high in RUN when the FIFO is not full.
REQ-012 A full FIFO SHALL deassert ready; a simultaneous pop and push on a full FIFO is not accepted that cycle.
REQ-013 The next counter value SHALL be next = taken ? (count==max ? max : count+1) : (count==0 ? 0 : count-1), where max = 2^JUMP_STATUS_COUNTER_WIDTH-1.
REQ-014 In RUN, a non-empty FIFO0 head SHALL be written on port 1 and popped in the same cycle; writes are registered outputs, one cycle after the head becomes visible.
REQ-015 In RUN, a non-empty FIFO1 head SHALL be written on port 2 and popped, except when a collision occurs.
REQ-016 A collision is both heads valid with equal index; its handling is set by REQ-021 and REQ-022.
REQ-017 Empty FIFOs SHALL leave the corresponding WR_en at 0; idle WR_index/WR_count SHALL hold their last values.
REQ-018 FIFO pointers SHALL wrap modulo QUEUE_DEPTH and keep a separate full/empty distinction through an extra pointer bit.

Reset
REQ-019 Asserting rst_n low SHALL immediately clear all state: FSM to CLEAR, ptr to 0, FIFOs empty, WR_en1/WR_en2 to 0, WR_index/WR_count to 0, init_done to 0, ready to 0.
REQ-020 Reset mid-CLEAR or mid-RUN SHALL discard queued updates and restart the clear from index 0.

Configuration
REQ-021 With PRED_UPD_MERGE_EN defined, a collision SHALL produce one port-1 write of next(next(head0.count, head0.taken), head1.taken), pop both heads, and hold WR_en2 at 0.
REQ-022 Without PRED_UPD_MERGE_EN, a collision SHALL write head0 on port 1 only; head1 stays queued and is written on a later cycle.

Structure
REQ-023 The shared package SHALL hold the FSM state encoding, the saturating next-count function, and the update-record typedef {index, count, taken}.
REQ-024 The FIFO SHALL be one sub-module, pred_upd_fifo, instantiated twice.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset release, default parameters -> 128 CLEAR cycles, every index written with 1, init_done rises on cycle 129, ready=0 throughout.
- RUN, upd0 {idx 5, count 3, taken 1} -> next cycle WR_en1=1, WR_index1=5, WR_count1=3; upd1 {idx 9, count 0, taken 0} -> WR_count2=0.
- Same-cycle upd0 {7, 1, 1} and upd1 {7, 2, 1}, merge build -> single WR_count1=3 at index 7; non-merge build -> WR_count1=2, then WR_count2=3 on the following cycle.
- Five pushes to requester 1 while repeated collisions stall it -> upd1_ready falls after the fourth push; the fifth is held until a pop.
- rst_n low mid-CLEAR (ptr=40) with FIFOs otherwise idle -> outputs reset at once; clear restarts at index 0 after release.
